// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequence controller.
// Holds the FSM encoding, default sizes and the legal-code check.
package johnson_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  // A Johnson code has at most one 0/1 boundary between adjacent bits.
  function automatic logic is_legal(
    input logic [MAX_W-1:0] code,
    input int               w
  );
    int trans;
    trans = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < w - 1 && code[i] != code[i+1]) begin
        trans++;
      end
    end
    return trans <= 1;
  endfunction

endpackage

// File: rtl/johnson_step_core.sv
// Johnson register with direction select and synchronous clear.
// Clear wins over advance; q resets asynchronously to zero.
module johnson_step_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (adv) begin
      if (dir) begin
        q <= {~q[0], q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
      end
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer around a Johnson counter: one-shot/continuous runs,
// hold/stop control and illegal-code recovery.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         hold,
  input  logic                         mode,
  input  logic                         dir,
  input  logic [CNT_W-1:0]             steps,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(2*WIDTH)-1:0]   phase,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int PH_W = $clog2(2*WIDTH);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] steps_l;
  logic             mode_l;
  logic             dir_l;
  logic             illegal;
  logic             adv;
  int unsigned      ones;

  assign illegal = !is_legal(MAX_W'(q), WIDTH);
  assign adv     = (state == RUN) && !illegal && !stop && !hold;
  assign busy    = (state != IDLE);

  johnson_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .dir (dir_l),
    .clr (illegal),
    .q   (q)
  );

  // Lower half of the cycle fills ones from the LSB, upper half drains them.
  always_comb begin
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + 32'(q[i]);
    end
    if (q[WIDTH-1]) begin
      phase = PH_W'(2*WIDTH - ones);
    end else begin
      phase = PH_W'(ones);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rem     <= '0;
      steps_l <= '0;
      mode_l  <= 1'b0;
      dir_l   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (illegal) begin
        state <= IDLE;
        rem   <= '0;
        err   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              steps_l <= steps;
              mode_l  <= mode;
              dir_l   <= dir;
              rem     <= steps;
              if (steps == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
            end else if (hold) begin
              state <= PAUSE;
            end else if (rem == CNT_W'(1)) begin
              done <= 1'b1;
              if (mode_l) begin
                rem <= steps_l;
              end else begin
                rem   <= '0;
                state <= DONE;
              end
            end else begin
              rem <= rem - CNT_W'(1);
            end
          end
          PAUSE: begin
            if (stop) begin
              state <= IDLE;
            end else if (!hold) begin
              state <= RUN;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: Johnson register width; 2*WIDTH legal codes.
REQ-002 Parameter CNT_W, default 8: width of the step-count request.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, asynchronous, active-low.
REQ-005 start  in  1: begin a sequence; sampled only in IDLE.
REQ-006 stop  in  1: abort the active sequence.
REQ-007 hold  in  1: freeze the active sequence while high.
REQ-008 mode  in  1: 0 = one-shot, 1 = continuous; latched on start.
REQ-009 dir  in  1: 0 = forward, 1 = reverse; latched on start.
REQ-010 steps  in  CNT_W: number of advances per sequence; latched on start.
REQ-011 q  out  WIDTH: Johnson counter value.
REQ-012 phase  out  $clog2(2*WIDTH): index 0..2*WIDTH-1 of q (0000=0, 0001=1 ... 1000=7 for WIDTH=4).
REQ-013 busy  out  1: high in RUN, PAUSE and DONE.
REQ-014 done  out  1: one-cycle completion pulse.
REQ-015 err  out  1: one-cycle illegal-code pulse.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-017 Forward advance: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; reverse advance: q <= {~q[0], q[WIDTH-1:1]}.
REQ-018 IDLE, start=1, steps!=0: latch steps/mode/dir into a remaining counter; go to RUN at that edge; q unchanged.
REQ-019 IDLE, start=1, steps=0: go to DONE at that edge with no advance.
REQ-020 RUN, no stop/hold: advance q once per cycle and decrement the remaining count; N steps give N advances on the N edges after the start edge.
REQ-021 RUN, last advance (remaining=1), one-shot: go to DONE on the same edge.
REQ-022 RUN, last advance, continuous: reload the remaining count from the latched steps, pulse done for one cycle, and stay in RUN without a gap cycle.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 RUN with hold=1: go to PAUSE with q frozen; PAUSE with hold=0: return to RUN; no advance on either transition edge.
REQ-025 stop=1 in RUN/PAUSE/DONE: go to IDLE next edge; q holds its value; no done pulse; stop in IDLE has no effect.
REQ-026 Priority per edge: illegal-code recovery > stop > hold > advance.
REQ-027 start while busy is ignored; it is not queued.
REQ-028 Illegal q (not one of the 2*WIDTH Johnson codes), in any state: next edge q <= 0, err=1 for one cycle, FSM to IDLE, no done.
REQ-029 phase and busy are combinational from q and state; done and err are registered.

Reset
REQ-030 rst low asynchronously forces q=0, phase=0, FSM=IDLE, remaining=0, busy=0, done=0, err=0.
REQ-031 Reset asserted mid-sequence aborts it with no done pulse.
REQ-032 After rst goes high, the first start is honoured on the first rising edge.

Structure
REQ-033 Package johnson_pkg holds: the FSM state enum, WIDTH/CNT_W defaults, and a legal-code check function.
REQ-034 Sub-module johnson_step_core holds the q register, the advance enable, dir, and the synchronous clear-to-zero; johnson_seq_ctrl holds the FSM and the remaining counter.

Verification
REQ-035 Reset, start, steps=5, dir=0, mode=0 -> q 0001,0011,0111,1111,1110 on five consecutive edges; done one cycle; busy low after done.
REQ-036 From q=0000, steps=3, dir=1 -> q 1000,1100,1110; phase 7,6,5; one done pulse.
REQ-037 steps=8, mode=1 -> done pulses every 8 cycles with q back to 0000 at each pulse; then stop -> IDLE, q held, no further done.
REQ-038 hold high for 3 cycles mid-run (steps=6) -> q frozen 3 cycles; 6 total advances; done delayed by 4 cycles (3 hold cycles plus 1 for the resume edge).
REQ-039 steps=0 -> no q change, busy for one cycle, done one cycle; start during RUN ignored.
REQ-040 Force q=0101 -> next edge q=0000, err one cycle, IDLE; rst low mid-run -> immediate q=0000, busy=0, no done.
